// File: rtl/timer_pkg.sv
// Shared timer definitions: default count width, FSM state encoding and the
// threshold that the downstream comparator and traffic-light FSM use.
package timer_pkg;

  localparam int         WIDTH_DEF = 8;
  localparam logic [7:0] THRESH_T0 = 8'hC8;

  typedef enum logic [1:0] {
    TMR_IDLE = 2'd0,
    TMR_RUN  = 2'd1,
    TMR_SAT  = 2'd2
  } tmr_state_t;

  // Comparator view of a timer value: t0 is strictly above the threshold.
  function automatic logic t0_of(input logic [WIDTH_DEF-1:0] v);
    return v > THRESH_T0;
  endfunction

endpackage

// File: rtl/state_timer_tick_prescaler.sv
// tick_prescaler: divides clk by CLK_DIV. It counts 0..CLK_DIV-1 while en is
// high and raises tc (combinational) during the cycle the counter sits at its
// terminal value, so the owner's registers update on that edge. clr dominates en.
module tick_prescaler #(
  parameter int CLK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  // One bit minimum so CLK_DIV=1 still elaborates; that counter stays at 0.
  localparam int            PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] TERM = PW'(CLK_DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  // Next prescaler value and terminal-count pulse.
  always_comb begin
    cnt_d = cnt_q;
    tc    = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == TERM) begin
        cnt_d = '0;
        tc    = 1'b1;
      end else begin
        cnt_d = cnt_q + PW'(1);
      end
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/state_timer.sv
// state_timer: prescaled, saturating tick counter feeding the threshold
// comparator. Three states: IDLE (hold), RUN (count), SAT (pinned at all ones).
// All outputs come straight from flops.
// Optional feature macro: TIMER_PRELOAD_EN adds load/load_val to preset the
// count from any state (priority start > load > stop > counting).
module state_timer
  import timer_pkg::*;
#(
  parameter int CLK_DIV = 1000,
  parameter int WIDTH   = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
`ifdef TIMER_PRELOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`endif
  output logic [WIDTH-1:0] timer_out,
  output logic             tick,
  output logic             busy,
  output logic             sat
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_PRE = CNT_MAX - WIDTH'(1);

  tmr_state_t       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic             sat_q, sat_d;
  logic             pre_en, pre_clr, pre_tc;

  tick_prescaler #(.CLK_DIV(CLK_DIV)) u_pre (
    .clk (clk),
    .rst (rst),
    .en  (pre_en),
    .clr (pre_clr),
    .tc  (pre_tc)
  );

  // Prescaler only advances in RUN, so it is frozen in IDLE and SAT.
  assign pre_en = (state_q == TMR_RUN);

  // Next-state, counter and tick decode. A start/load/stop cycle discards
  // any tick that would otherwise land on the same edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    pre_clr = 1'b0;
    if (start) begin
      state_d = TMR_RUN;
      cnt_d   = '0;
      pre_clr = 1'b1;
`ifdef TIMER_PRELOAD_EN
    end else if (load) begin
      state_d = (load_val == CNT_MAX) ? TMR_SAT : TMR_RUN;
      cnt_d   = load_val;
      pre_clr = 1'b1;
`endif
    end else begin
      case (state_q)
        TMR_RUN: begin
          if (stop) begin
            state_d = TMR_IDLE;
            pre_clr = 1'b1;
          end else if (pre_tc) begin
            tick_d = 1'b1;
            cnt_d  = cnt_q + WIDTH'(1);
            if (cnt_q == CNT_PRE) state_d = TMR_SAT;
          end
        end
        TMR_SAT:  state_d = TMR_SAT;
        default:  state_d = TMR_IDLE;
      endcase
    end
    busy_d = (state_d == TMR_RUN);
    sat_d  = (state_d == TMR_SAT);
  end

  // State, count and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TMR_IDLE;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      sat_q   <= sat_d;
    end
  end

  assign timer_out = cnt_q;
  assign tick      = tick_q;
  assign busy      = busy_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_state_timer.sv
// Directed bench for state_timer with CLK_DIV=4, WIDTH=8. A vector table
// drives start/stop pulses, advances a fixed number of clocks and compares
// all outputs; async reset and preload are covered by short hand sequences.
module tb_state_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] timer_out;
  logic       tick, busy, sat;
`ifdef TIMER_PRELOAD_EN
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  state_timer #(.CLK_DIV(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
`ifdef TIMER_PRELOAD_EN
    .load      (load),
    .load_val  (load_val),
`endif
    .timer_out (timer_out),
    .tick      (tick),
    .busy      (busy),
    .sat       (sat)
  );

  typedef struct {
    string      name;
    logic       start;
    logic       stop;
    int         n;       // clk edges to advance, the first one samples the pulses
    logic [7:0] e_tmr;
    logic       e_busy;
    logic       e_sat;
    logic       e_tick;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string nm, logic s, logic p, int n,
                              logic [7:0] t, logic b, logic st, logic k);
    vec_t v;
    v.name = nm; v.start = s; v.stop = p; v.n = n;
    v.e_tmr = t; v.e_busy = b; v.e_sat = st; v.e_tick = k;
    vecs.push_back(v);
  endfunction

  task automatic check(string nm, logic [7:0] t, logic b, logic st, logic k);
    n_vec++;
    if (timer_out !== t || busy !== b || sat !== st || tick !== k) begin
      n_bad++;
      $display("FAIL %s: got tmr=%h busy=%b sat=%b tick=%b, want tmr=%h busy=%b sat=%b tick=%b",
               nm, timer_out, busy, sat, tick, t, b, st, k);
    end
  endtask

  // Comparator output derived independently from the expected count.
  task automatic check_t0(string nm, logic e_t0);
    n_vec++;
    if ((timer_out > 8'hC8) !== e_t0) begin
      n_bad++;
      $display("FAIL %s: got t0=%b, want t0=%b", nm, timer_out > 8'hC8, e_t0);
    end
  endtask

  // Entered and left just after a negedge with all pulses low.
  task automatic apply(vec_t v);
    start = v.start;
    stop  = v.stop;
    for (int i = 0; i < v.n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start = 1'b0;
        stop  = 1'b0;
      end
    end
    check(v.name, v.e_tmr, v.e_busy, v.e_sat, v.e_tick);
  endtask

  initial begin
    //   name            st  sp  n    tmr    busy sat tick
    add("start_idle",    1, 0,   1, 8'h00, 1, 0, 0);
    add("pre_3",         0, 0,   3, 8'h00, 1, 0, 0);
    add("first_tick",    0, 0,   1, 8'h01, 1, 0, 1);
    add("tick_1cyc",     0, 0,   1, 8'h01, 1, 0, 0);
    add("second_tick",   0, 0,   3, 8'h02, 1, 0, 1);
    add("cnt_200",       0, 0, 792, 8'hC8, 1, 0, 1);
    add("cnt_201",       0, 0,   4, 8'hC9, 1, 0, 1);
    add("cnt_254",       0, 0, 212, 8'hFE, 1, 0, 1);
    add("saturate",      0, 0,   4, 8'hFF, 0, 1, 1);
    add("sat_hold",      0, 0,  20, 8'hFF, 0, 1, 0);
    add("start_sat",     1, 0,   1, 8'h00, 1, 0, 0);
    add("cnt_50",        0, 0, 200, 8'h32, 1, 0, 1);
    add("start_stop",    1, 1,   1, 8'h00, 1, 0, 0);
    add("cnt_9",         0, 0,  36, 8'h09, 1, 0, 1);
    add("stop_run",      0, 1,   1, 8'h09, 0, 0, 0);
    add("idle_hold",     0, 0,  10, 8'h09, 0, 0, 0);
    add("stop_idle",     0, 1,   1, 8'h09, 0, 0, 0);
    add("restart",       1, 0,   1, 8'h00, 1, 0, 0);
    add("tick_due",      0, 0,   3, 8'h00, 1, 0, 0);
    add("start_on_tick", 1, 0,   1, 8'h00, 1, 0, 0);
    add("pre_cleared",   0, 0,   3, 8'h00, 1, 0, 0);
    add("tick_after",    0, 0,   1, 8'h01, 1, 0, 1);
    add("tick_due2",     0, 0,   3, 8'h01, 1, 0, 0);
    add("stop_on_tick",  0, 1,   1, 8'h01, 0, 0, 0);
    add("idle_no_tick",  0, 0,   5, 8'h01, 0, 0, 0);

    // Reset state while rst is held.
    #12;
    check("reset_state", 8'h00, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset", 8'h00, 0, 0, 0);

    foreach (vecs[i]) begin
      apply(vecs[i]);
      if (vecs[i].name == "cnt_200") check_t0("t0_at_200", 1'b0);
      if (vecs[i].name == "cnt_201") check_t0("t0_at_201", 1'b1);
    end

    // Async reset mid-RUN at count 37: outputs clear before the next clk edge.
    begin
      vec_t v;
      v.name = "run_to_37"; v.start = 1'b1; v.stop = 1'b0; v.n = 1;
      v.e_tmr = 8'h00; v.e_busy = 1'b1; v.e_sat = 1'b0; v.e_tick = 1'b0;
      apply(v);
      v.start = 1'b0; v.n = 148; v.e_tmr = 8'h25; v.e_tick = 1'b1;
      apply(v);
    end
    #2 rst = 1'b1;
    #1 check("async_reset", 8'h00, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_after_rst", 8'h00, 0, 0, 0);

`ifdef TIMER_PRELOAD_EN
    load = 1'b1; load_val = 8'hC7;
    @(negedge clk);
    load = 1'b0;
    check("load_c7", 8'hC7, 1, 0, 0);
    repeat (8) @(negedge clk);
    check("load_c7_plus2", 8'hC9, 1, 0, 1);
    load = 1'b1; load_val = 8'hFF;
    @(negedge clk);
    load = 1'b0;
    check("load_ff", 8'hFF, 0, 1, 0);
    repeat (8) @(negedge clk);
    check("load_ff_hold", 8'hFF, 0, 1, 0);
    load = 1'b1; load_val = 8'h10; start = 1'b1;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    check("start_over_load", 8'h00, 1, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
